// File: rtl/bp_cfg_param_streamer.sv
// Writable table of processor parameter sets. A request validates one set and
// streams its fields over a valid/ready link; entry 0 is always the invalid config.
module bp_cfg_param_streamer #(
    parameter int num_cfgs_p     = 16,
    parameter int fields_p       = 32,
    parameter int field_width_p  = 16,
    parameter int dim_x_field_p  = 0,
    parameter int dim_y_field_p  = 1,
    parameter int assoc_field_p  = 2,
    localparam int lg_num_cfgs_lp = (num_cfgs_p == 1) ? 1 : $clog2(num_cfgs_p),
    localparam int lg_fields_lp   = (fields_p == 1) ? 1 : $clog2(fields_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      w_v_i,
    input  logic [lg_num_cfgs_lp-1:0] w_cfg_i,
    input  logic [lg_fields_lp-1:0]   w_field_i,
    input  logic [field_width_p-1:0]  w_data_i,
    output logic                      w_ready_o,
    input  logic                      req_v_i,
    input  logic [lg_num_cfgs_lp-1:0] req_cfg_i,
    output logic                      req_ready_o,
    output logic                      data_v_o,
    output logic [lg_fields_lp-1:0]   data_field_o,
    output logic [field_width_p-1:0]  data_o,
    output logic                      data_last_o,
    input  logic                      data_ready_i,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o
);

    typedef enum logic [2:0] {
        st_idle  = 3'd0,
        st_check = 3'd1,
        st_send  = 3'd2,
        st_done  = 3'd3,
        st_err   = 3'd4
    } state_e;

    localparam logic [lg_num_cfgs_lp:0]  num_cfgs_lim = (lg_num_cfgs_lp+1)'(num_cfgs_p);
    localparam logic [lg_fields_lp:0]    fields_lim   = (lg_fields_lp+1)'(fields_p);
    localparam logic [lg_fields_lp-1:0]  last_field   = lg_fields_lp'(fields_p - 1);
    localparam logic [field_width_p-1:0] field_one    = field_width_p'(1);

    state_e                      state_r, state_s;
    logic [lg_num_cfgs_lp-1:0]   cfg_r;
    logic [lg_fields_lp-1:0]     cnt_r;
    logic [1:0]                  err_code_r, err_code_s;
    logic [field_width_p-1:0]    mem_r [num_cfgs_p][fields_p];

    logic                        cfg_ok_s;
    logic [lg_num_cfgs_lp-1:0]   cfg_idx_s;
    logic [field_width_p-1:0]    dim_x_s, dim_y_s, assoc_s;
    logic                        w_en_s;
    logic                        hs_s;
    logic                        cnt_last_s;

    assign cfg_ok_s   = (cfg_r != '0) && ({1'b0, cfg_r} < num_cfgs_lim);
    // Out-of-range indices read entry 0; the index error masks the value checks anyway.
    assign cfg_idx_s  = cfg_ok_s ? cfg_r : '0;
    assign dim_x_s    = mem_r[cfg_idx_s][dim_x_field_p];
    assign dim_y_s    = mem_r[cfg_idx_s][dim_y_field_p];
    assign assoc_s    = mem_r[cfg_idx_s][assoc_field_p];
    assign w_en_s     = w_v_i && w_ready_o && (w_cfg_i != '0) &&
                        ({1'b0, w_cfg_i} < num_cfgs_lim) && ({1'b0, w_field_i} < fields_lim);
    assign hs_s       = data_v_o && data_ready_i;
    assign cnt_last_s = (cnt_r == last_field);

    // Validation of the latched entry, in priority order.
    always_comb begin
        err_code_s = 2'd0;
        if (!cfg_ok_s) begin
            err_code_s = 2'd1;
        end else if ((dim_x_s == '0) || (dim_y_s == '0)) begin
            err_code_s = 2'd2;
        end else if ((assoc_s == '0) || ((assoc_s & (assoc_s - field_one)) != '0)) begin
            err_code_s = 2'd3;
        end else begin
            err_code_s = 2'd0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= st_idle;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            st_idle:  state_s = (req_v_i && req_ready_o) ? st_check : st_idle;
            st_check: state_s = (err_code_s != 2'd0) ? st_err : st_send;
            st_send:  state_s = (hs_s && cnt_last_s) ? st_done : st_send;
            st_done:  state_s = st_idle;
            st_err:   state_s = st_idle;
            default:  state_s = st_idle;
        endcase
    end

    // Latched request index, beat counter and error code.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cfg_r      <= '0;
            cnt_r      <= '0;
            err_code_r <= 2'd0;
        end else begin
            case (state_r)
                st_idle: begin
                    if (req_v_i && req_ready_o) begin
                        cfg_r <= req_cfg_i;
                    end
                end
                st_check: begin
                    cnt_r      <= '0;
                    err_code_r <= err_code_s;
                end
                st_send: begin
                    if (hs_s && !cnt_last_s) begin
                        cnt_r <= cnt_r + lg_fields_lp'(1);
                    end
                end
                st_err:  err_code_r <= 2'd0;
                default: err_code_r <= err_code_r;
            endcase
        end
    end

    // Parameter table; writes only land in IDLE, so a stream sees a frozen entry.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < num_cfgs_p; c++) begin
                for (int f = 0; f < fields_p; f++) begin
                    mem_r[c][f] <= '0;
                end
            end
        end else if (w_en_s) begin
            mem_r[w_cfg_i][w_field_i] <= w_data_i;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        w_ready_o    = 1'b0;
        req_ready_o  = 1'b0;
        data_v_o     = 1'b0;
        data_field_o = '0;
        data_o       = '0;
        data_last_o  = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        err_code_o   = 2'd0;
        case (state_r)
            st_idle: begin
                w_ready_o   = 1'b1;
                req_ready_o = !w_v_i;
            end
            st_send: begin
                data_v_o     = 1'b1;
                data_field_o = cnt_r;
                data_o       = mem_r[cfg_idx_s][cnt_r];
                data_last_o  = cnt_last_s;
            end
            st_done: done_o = 1'b1;
            st_err: begin
                err_o      = 1'b1;
                err_code_o = err_code_r;
            end
            default: begin
                w_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/bp_cfg_param_streamer.md
Name: bp_cfg_param_streamer

Overview:
- Runtime successor to the static processor-config table: holds `num_cfgs_p` writable parameter sets, each made of `fields_p` fields.
- On request, it validates the selected set and streams its fields out over a valid/ready link to the configuration bus at boot.
- Entry 0 is permanently the invalid config, mirroring the enum convention.
- It sits between the host loader and the per-tile config endpoints.

Parameters:
- num_cfgs_p, 16, number of config entries; index 0 reserved invalid.
- fields_p, 32, fields per config entry.
- field_width_p, 16, bits per field.
- dim_x_field_p, 0, field index holding cc_x_dim.
- dim_y_field_p, 1, field index holding cc_y_dim.
- assoc_field_p, 2, field index holding dcache_assoc; must be a power of two.
- lg_num_cfgs_lp, `BSG_SAFE_CLOG2(num_cfgs_p)`, derived.
- lg_fields_lp, `BSG_SAFE_CLOG2(fields_p)`, derived.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- w_v_i  in  1  table write valid
- w_cfg_i  in  lg_num_cfgs_lp  entry written
- w_field_i  in  lg_fields_lp  field written
- w_data_i  in  field_width_p  write data
- w_ready_o  out  1  write accepted when w_v_i & w_ready_o
- req_v_i  in  1  stream request valid
- req_cfg_i  in  lg_num_cfgs_lp  entry to stream
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o
- data_v_o  out  1  stream field valid
- data_field_o  out  lg_fields_lp  index of current field
- data_o  out  field_width_p  field value
- data_last_o  out  1  current field is fields_p-1
- data_ready_i  in  1  downstream ready
- done_o  out  1  one-cycle pulse after last field transferred
- err_o  out  1  one-cycle pulse on rejected request
- err_code_o  out  2  valid with err_o; 1 = bad index, 2 = zero dimension, 3 = non-power-of-two assoc

Behaviour:
- Reset (asynchronous, active-high): FSM to IDLE; all table fields cleared to 0; counter 0; data_v_o, done_o, err_o = 0; err_code_o = 0.
- Consequence of reset: every entry is invalid (zero dims) until loaded. Reset asserted mid-stream aborts immediately with no done_o or err_o.
- FSM states: IDLE, CHECK, SEND, DONE, ERR.
- IDLE:
  - w_ready_o = 1; req_ready_o = ~w_v_i, so a write wins over a same-cycle request.
  - A write updates the table at the clock edge.
  - An accepted request latches req_cfg_i -> CHECK.
  - A write to entry 0 is accepted but discarded; entry 0 stays all-zero.
- Outside IDLE: w_ready_o = 0 and req_ready_o = 0.
- CHECK (1 cycle):
  - Error checks in priority order:
    - latched index == 0 or >= num_cfgs_p -> code 1;
    - x-dim field == 0 or y-dim field == 0 -> code 2;
    - assoc field == 0 or (a & (a-1)) != 0 -> code 3.
  - Any error -> ERR; otherwise -> SEND with counter = 0.
- SEND:
  - data_v_o = 1; data_field_o = counter; data_o = table[cfg][counter].
  - data_last_o = (counter == fields_p-1).
  - On data_v_o & data_ready_i: counter increments; on the last field -> DONE.
  - data_o and data_field_o hold stable while data_ready_i is low.
  - Stalls may be unbounded.
- DONE: done_o = 1 for exactly one cycle -> IDLE.
- ERR: err_o = 1 with err_code_o for exactly one cycle -> IDLE. err_code_o returns to 0 afterwards.
- Latency:
  - Request accept to first data_v_o = 2 cycles (accept edge, CHECK).
  - With data_ready_i held high, a full stream takes fields_p cycles.
  - Request accept to done_o = fields_p + 2 cycles.
  - The next request is accepted the cycle after done_o or err_o.
- Table contents cannot change during a stream, because writes are blocked outside IDLE.
- fields_p == 1: first field is also last; data_last_o is high on the only beat.
- The counter never wraps; it is reset to 0 on entering SEND.

Test Plan:
- Reset, then request cfg 3 with no writes -> err_o pulse with err_code_o = 2 two cycles after accept; no data_v_o.
- Load cfg 3 with fields i = i+1 (assoc field = 3), request cfg 3 -> err_code_o = 3. Rewrite assoc field to 8, request again -> 32 beats, data_o = 1,2,8,4,...,32 (field 2 = 8); data_last_o only on field 31; done_o on the cycle after the last beat.
- Request cfg 0 and cfg 15 when num_cfgs_p = 12 -> err_code_o = 1 both times. Write to entry 0 then request cfg 0 -> still err_code_o = 1.
- Random data_ready_i at 30% during a valid stream -> field order strictly 0..31; data_o/data_field_o held stable across stalls; done_o only after 32 handshakes.
- Same-cycle w_v_i and req_v_i in IDLE -> write applied, req_ready_o = 0. Writes attempted during SEND -> w_ready_o = 0 and table unchanged, confirmed by a re-stream.
- Assert reset_i at beat 10 of a stream -> data_v_o falls immediately; no done_o; table reads all zero afterwards, so a request returns err_code_o = 2.
